display_scheduler: RTL and testbench

- Time-shares the 4-digit seven-segment display between a steady status view (octave/volume) and transient focus views.
- Transient views are triggered by volume/octave change events and by note-name requests from the player.
- Sits between the settings/player logic and the segment decoder/scanner; drives four 4-bit digit codes.
- Each focus view is held for a programmable time, then the block returns to status.

---
 rtl/disp_pkg.sv | 33 +++
 rtl/hold_timer.sv | 28 ++
 rtl/display_scheduler.sv | 121 ++++++++++++
 tb/tb_display_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared codes, scheduler states and display-frame packing for the 4-digit display path.
package disp_pkg;

  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] CODE_DASH  = 4'd8;
  localparam logic [CODE_W-1:0] CODE_BLANK = 4'd15;

  typedef enum logic [1:0] {
    STATUS,
    VOL_F,
    OCT_F,
    NOTE_F
  } state_e;

  // d3 is the leftmost digit, d0 the rightmost
  typedef struct packed {
    logic [CODE_W-1:0] d3;
    logic [CODE_W-1:0] d2;
    logic [CODE_W-1:0] d1;
    logic [CODE_W-1:0] d0;
  } frame_t;

  localparam frame_t FRAME_BLANK = '{CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_BLANK};

  function automatic frame_t STATUS_FRAME(input logic [CODE_W-1:0] c3,
                                          input logic [CODE_W-1:0] c2,
                                          input logic [CODE_W-1:0] c1,
                                          input logic [CODE_W-1:0] c0);
    return '{c3, c2, c1, c0};
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Down-counter timing how long a focus view stays on screen.
module hold_timer #(
  parameter int unsigned TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] value,
  input  logic          tick,
  output logic          expired
);

  logic [TW-1:0] count_q;

  // Saturates at zero so a suppressed expiry is seen again next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - TW'(1);
    end
  end

  assign expired = tick && (count_q == '0);

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the seven-segment display between the status view and transient focus views.
module display_scheduler
  import disp_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  volume,
  input  logic [2:0]  octave,
  input  logic        vol_evt,
  input  logic        oct_evt,
  input  logic        note_req,
  input  logic [3:0]  note_code,
  output logic        note_ack,
  input  logic        blank,
  output logic [15:0] disp_codes,
  output logic        busy
);

  localparam int unsigned   TW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic        oct_pend_q, oct_pend_d;
  logic [3:0]  note_q, note_d;
  logic        ack_d;
  logic        busy_d;
  frame_t      disp_q, disp_d;
  frame_t      view_frame;
  logic        tmr_load;
  logic        tmr_tick;
  logic        tmr_expired;

  assign tmr_tick = (state_q != STATUS);

  hold_timer #(
    .TW (TW)
  ) u_hold_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .value   (HOLD_LOAD),
    .tick    (tmr_tick),
    .expired (tmr_expired)
  );

  // Next-state: vol_evt > oct_evt > hold expiry > note request
  always_comb begin
    state_d    = state_q;
    oct_pend_d = oct_pend_q;
    note_d     = note_q;
    ack_d      = 1'b0;
    tmr_load   = 1'b0;

    if (vol_evt) begin
      state_d  = VOL_F;
      tmr_load = 1'b1;
      if (oct_evt) begin
        oct_pend_d = 1'b1;
      end
    end else if (oct_evt) begin
      if (state_q == VOL_F) begin
        oct_pend_d = 1'b1;
      end else begin
        state_d  = OCT_F;
        tmr_load = 1'b1;
      end
    end else if (tmr_expired) begin
      if ((state_q == VOL_F) && oct_pend_q) begin
        state_d    = OCT_F;
        oct_pend_d = 1'b0;
        tmr_load   = 1'b1;
      end else begin
        state_d = STATUS;
      end
    end else if (note_req && !note_ack && !oct_pend_q &&
                 ((state_q == STATUS) || (state_q == NOTE_F))) begin
      state_d  = NOTE_F;
      note_d   = note_code;
      ack_d    = 1'b1;
      tmr_load = 1'b1;
    end

    busy_d = (state_d != STATUS);
  end

  // Frame for the view being entered, using this cycle's volume/octave
  always_comb begin
    view_frame = FRAME_BLANK;
    case (state_d)
      STATUS:  view_frame = STATUS_FRAME(CODE_DASH, 4'(octave), 4'(volume), CODE_DASH);
      VOL_F:   view_frame = STATUS_FRAME(CODE_BLANK, CODE_BLANK, CODE_DASH, 4'(volume));
      OCT_F:   view_frame = STATUS_FRAME(CODE_BLANK, CODE_BLANK, CODE_DASH, 4'(octave));
      NOTE_F:  view_frame = STATUS_FRAME(CODE_BLANK, CODE_BLANK, CODE_BLANK, note_d);
      default: view_frame = FRAME_BLANK;
    endcase
    disp_d = blank ? FRAME_BLANK : view_frame;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STATUS;
      oct_pend_q <= 1'b0;
      note_q     <= 4'd0;
      note_ack   <= 1'b0;
      busy       <= 1'b0;
      disp_q     <= FRAME_BLANK;
    end else begin
      state_q    <= state_d;
      oct_pend_q <= oct_pend_d;
      note_q     <= note_d;
      note_ack   <= ack_d;
      busy       <= busy_d;
      disp_q     <= disp_d;
    end
  end

  assign disp_codes = disp_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed and randomized checks of display_scheduler against a cycle-count view model.
module tb_display_scheduler;

  localparam int unsigned HOLD = 10;
  localparam int V_STATUS = 0;
  localparam int V_VOL    = 1;
  localparam int V_OCT    = 2;
  localparam int V_NOTE   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  volume;
  logic [2:0]  octave;
  logic        vol_evt;
  logic        oct_evt;
  logic        note_req;
  logic [3:0]  note_code;
  logic        note_ack;
  logic        blank;
  logic [15:0] disp_codes;
  logic        busy;

  always #5 clk = ~clk;

  display_scheduler #(
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .volume     (volume),
    .octave     (octave),
    .vol_evt    (vol_evt),
    .oct_evt    (oct_evt),
    .note_req   (note_req),
    .note_code  (note_code),
    .note_ack   (note_ack),
    .blank      (blank),
    .disp_codes (disp_codes),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: which view is on screen and how many cycles it still has
  int          m_view;
  int          m_rem;
  logic        m_pend;
  logic        m_ack;
  logic [3:0]  m_note;
  logic [15:0] m_disp;
  bit          sticky_req;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] frame_of(input int view, input logic [2:0] v,
                                           input logic [2:0] o, input logic [3:0] n);
    case (view)
      V_STATUS: return 16'h8008 | (16'(o) << 8) | (16'(v) << 4);
      V_VOL:    return 16'hFF80 | 16'(v);
      V_OCT:    return 16'hFF80 | 16'(o);
      default:  return 16'hFFF0 | 16'(n);
    endcase
  endfunction

  task automatic model_reset();
    m_view = V_STATUS;
    m_rem  = 0;
    m_pend = 1'b0;
    m_ack  = 1'b0;
    m_note = 4'd0;
    m_disp = 16'hFFFF;
  endtask

  // One clock of the display rules; a view can never end in a cycle carrying an event
  task automatic model_step();
    logic ack_prev;
    ack_prev = m_ack;
    m_ack    = 1'b0;
    if (vol_evt) begin
      m_view = V_VOL;
      m_rem  = HOLD;
      if (oct_evt) m_pend = 1'b1;
    end else if (oct_evt) begin
      if (m_view == V_VOL) begin
        m_pend = 1'b1;
        if (m_rem > 1) m_rem--;
      end else begin
        m_view = V_OCT;
        m_rem  = HOLD;
      end
    end else if (m_view != V_STATUS && m_rem == 1) begin
      if (m_view == V_VOL && m_pend) begin
        m_view = V_OCT;
        m_rem  = HOLD;
        m_pend = 1'b0;
      end else begin
        m_view = V_STATUS;
      end
    end else if (note_req && !ack_prev && (m_view == V_STATUS || m_view == V_NOTE)) begin
      m_view = V_NOTE;
      m_note = note_code;
      m_rem  = HOLD;
      m_ack  = 1'b1;
    end else if (m_view != V_STATUS) begin
      m_rem--;
    end
    m_disp = blank ? 16'hFFFF : frame_of(m_view, volume, octave, m_note);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("disp", disp_codes, m_disp);
    chk("busy", 16'(busy), 16'(m_view != V_STATUS));
    chk("ack", 16'(note_ack), 16'(m_ack));
    if (note_ack && !sticky_req) note_req = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    rst_n    = 1'b0;
    vol_evt  = 1'b0;
    oct_evt  = 1'b0;
    note_req = 1'b0;
    model_reset();
    #1;
    chk("rst_disp", disp_codes, 16'hFFFF);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_ack", 16'(note_ack), 16'd0);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_hold_disp", disp_codes, 16'hFFFF);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    volume     = 3'd3;
    octave     = 3'd4;
    vol_evt    = 1'b0;
    oct_evt    = 1'b0;
    note_req   = 1'b0;
    note_code  = 4'd0;
    blank      = 1'b0;
    sticky_req = 1'b0;
    apply_reset(3);

    tick();
    chk("post_rst_frame", disp_codes, 16'h8438);
    chk("post_rst_busy", 16'(busy), 16'd0);

    // Volume focus and its hold length
    volume  = 3'd5;
    vol_evt = 1'b1;
    tick();
    vol_evt = 1'b0;
    chk("vol_entry", disp_codes, 16'hFF85);
    chk("vol_busy", 16'(busy), 16'd1);
    repeat (HOLD - 1) tick();
    chk("vol_held", disp_codes, 16'hFF85);
    tick();
    chk("vol_exit", disp_codes, 16'h8458);

    // Simultaneous events: volume view then queued octave view
    octave  = 3'd2;
    vol_evt = 1'b1;
    oct_evt = 1'b1;
    tick();
    vol_evt = 1'b0;
    oct_evt = 1'b0;
    chk("dual_vol", disp_codes, 16'hFF85);
    repeat (HOLD - 1) tick();
    tick();
    chk("dual_oct", disp_codes, 16'hFF82);
    repeat (HOLD - 1) tick();
    chk("dual_oct_held", disp_codes, 16'hFF82);
    tick();
    chk("dual_exit", disp_codes, 16'h8258);

    // Note request, then a replacing request inside the hold
    note_code = 4'd6;
    note_req  = 1'b1;
    tick();
    chk("note_ack", 16'(note_ack), 16'd1);
    chk("note_frame", disp_codes, 16'hFFF6);
    tick();
    chk("note_ack_pulse", 16'(note_ack), 16'd0);
    tick();
    note_code = 4'd1;
    note_req  = 1'b1;
    tick();
    chk("note2_ack", 16'(note_ack), 16'd1);
    chk("note2_frame", disp_codes, 16'hFFF1);
    repeat (HOLD - 1) tick();
    chk("note2_held", disp_codes, 16'hFFF1);
    tick();
    chk("note_exit", disp_codes, 16'h8258);

    // Note request waits out an octave view
    octave  = 3'd7;
    oct_evt = 1'b1;
    tick();
    oct_evt = 1'b0;
    chk("oct_entry", disp_codes, 16'hFF87);
    note_code = 4'd3;
    note_req  = 1'b1;
    for (int i = 0; i < int'(HOLD) - 1; i++) begin
      tick();
      chk("oct_no_ack", 16'(note_ack), 16'd0);
    end
    tick();
    chk("oct_exit", disp_codes, 16'h8758);
    chk("oct_exit_ack", 16'(note_ack), 16'd0);
    tick();
    chk("late_ack", 16'(note_ack), 16'd1);
    chk("late_note", disp_codes, 16'hFFF3);

    // Blanked volume view preempting the note; timer keeps running
    tick();
    vol_evt = 1'b1;
    blank   = 1'b1;
    tick();
    vol_evt = 1'b0;
    chk("blank_vol", disp_codes, 16'hFFFF);
    chk("blank_busy", 16'(busy), 16'd1);
    repeat (HOLD - 1) tick();
    chk("blank_busy_end", 16'(busy), 16'd1);
    tick();
    chk("blank_expired_busy", 16'(busy), 16'd0);
    chk("blank_still", disp_codes, 16'hFFFF);
    blank = 1'b0;
    tick();
    chk("unblank", disp_codes, 16'h8758);

    // Reset in the middle of a focus view
    vol_evt = 1'b1;
    tick();
    vol_evt = 1'b0;
    tick();
    tick();
    apply_reset(2);
    tick();
    chk("reset_recover", disp_codes, 16'h8758);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      vol_evt = ($urandom_range(0, 11) == 0);
      oct_evt = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) volume = 3'($urandom);
      if ($urandom_range(0, 7) == 0) octave = 3'($urandom);
      if ($urandom_range(0, 29) == 0) blank = ~blank;
      if (!note_req && $urandom_range(0, 5) == 0) begin
        note_req  = 1'b1;
        note_code = 4'($urandom);
      end
      sticky_req = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) apply_reset(1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
